// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared enums and flag indices for the parametrised datapath
package datapath_pkg;

   typedef enum logic [2:0] {
      ALU_ADD   = 3'd0,
      ALU_SUB   = 3'd1,
      ALU_AND   = 3'd2,
      ALU_OR    = 3'd3,
      ALU_XOR   = 3'd4,
      ALU_INC   = 3'd5,
      ALU_DEC   = 3'd6,
      ALU_PASSB = 3'd7
   } alu_op_e;

   typedef enum logic [1:0] {
      BUS1_PC  = 2'd0,
      BUS1_RF  = 2'd1,
      BUS1_MDR = 2'd2,
      BUS1_SP  = 2'd3
   } bus1_sel_e;

   typedef enum logic [1:0] {
      BUS2_ALU  = 2'd0,
      BUS2_BUS1 = 2'd1,
      BUS2_MDR  = 2'd2,
      BUS2_ZERO = 2'd3
   } bus2_sel_e;

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_WAIT = 1'b1
   } rd_state_e;

   // Bit positions inside the {N,Z,V,C} condition-code vector
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_C = 0;

endpackage

// File: rtl/datapath_param_if.sv
// rtl/datapath_param_if.sv - memory-side bus between the datapath and the memory model
interface datapath_param_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
);
   logic              mem_rd;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] to_memory;

   modport master (
      output mem_rd,
      output address,
      output to_memory,
      input  mem_rvalid,
      input  mem_rdata
   );

   modport slave (
      input  mem_rd,
      input  address,
      input  to_memory,
      output mem_rvalid,
      output mem_rdata
   );
endinterface

// File: rtl/datapath_param_alu.sv
// rtl/datapath_param_alu.sv - combinational DATA_W-bit ALU producing result and NZVC flags
module alu_param
   import datapath_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  alu_op_e           op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result,
   output logic [3:0]        nzvc
);
   localparam int MSB = DATA_W - 1;
   localparam logic [DATA_W:0] ONE = (DATA_W + 1)'(1);

   logic [DATA_W:0] ext;
   logic            ovf;

   // ext[DATA_W] is carry-out on additions and borrow-out on subtractions
   always_comb begin
      ext = '0;
      ovf = 1'b0;
      case (op)
         ALU_ADD: begin
            ext = {1'b0, a} + {1'b0, b};
            ovf = (a[MSB] == b[MSB]) && (ext[MSB] != a[MSB]);
         end
         ALU_SUB: begin
            ext = {1'b0, a} - {1'b0, b};
            ovf = (a[MSB] != b[MSB]) && (ext[MSB] != a[MSB]);
         end
         ALU_AND: ext = {1'b0, a & b};
         ALU_OR:  ext = {1'b0, a | b};
         ALU_XOR: ext = {1'b0, a ^ b};
         ALU_INC: begin
            ext = {1'b0, b} + ONE;
            ovf = !b[MSB] && ext[MSB];
         end
         ALU_DEC: begin
            ext = {1'b0, b} - ONE;
            ovf = b[MSB] && !ext[MSB];
         end
         ALU_PASSB: ext = {1'b0, b};
         default: ext = '0;
      endcase
   end

   always_comb begin
      result         = ext[DATA_W-1:0];
      nzvc           = '0;
      nzvc[FLAG_N]   = ext[MSB];
      nzvc[FLAG_Z]   = (ext[DATA_W-1:0] == '0);
      nzvc[FLAG_V]   = ovf;
      nzvc[FLAG_C]   = ext[DATA_W];
   end

endmodule

// File: rtl/datapath_param.sv
// rtl/datapath_param.sv - parametrised CPU datapath with register file and stallable memory read
// Optional stack pointer enabled by defining DP_STACK_EN.
module datapath_param
   import datapath_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int NREGS  = 4,
   localparam int RIDX_W = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ir_load,
   input  logic              mar_load,
   input  logic              pc_load,
   input  logic              pc_inc,
   input  logic              rf_load,
   input  logic [RIDX_W-1:0] rf_wr_idx,
   input  logic [RIDX_W-1:0] rf_rd_idx,
   input  logic [RIDX_W-1:0] alu_a_idx,
   input  logic [2:0]        alu_sel,
   input  logic              ccr_load,
   input  logic [1:0]        bus1_sel,
   input  logic [1:0]        bus2_sel,
   input  logic              mem_rd_req,
   input  logic              sp_push,
   input  logic              sp_pop,
   output logic              mem_busy,
   output logic              mdr_valid,
   output logic [DATA_W-1:0] ir,
   output logic [3:0]        ccr_result,
   datapath_param_if.master  mem
);
   localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] mar;
   logic [DATA_W-1:0] mdr;
   logic [DATA_W-1:0] rf [NREGS];
   logic [DATA_W-1:0] bus1;
   logic [DATA_W-1:0] bus2;
   logic [DATA_W-1:0] sp_bus;
   logic [DATA_W-1:0] alu_result;
   logic [3:0]        alu_nzvc;
   rd_state_e         rd_state;
   rd_state_e         rd_next;
   logic              rd_capture;

`ifdef DP_STACK_EN
   logic [ADDR_W-1:0] sp;

   // Simultaneous push and pop cancel out and leave SP unchanged
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sp <= '1;
      end else if (sp_push && !sp_pop) begin
         sp <= sp - PC_ONE;
      end else if (sp_pop && !sp_push) begin
         sp <= sp + PC_ONE;
      end
   end

   assign sp_bus = DATA_W'(sp);
`else
   logic unused_stack_strobes;

   assign unused_stack_strobes = sp_push | sp_pop;
   assign sp_bus               = '0;
`endif

   always_comb begin
      bus1 = '0;
      case (bus1_sel_e'(bus1_sel))
         BUS1_PC:  bus1 = DATA_W'(pc);
         BUS1_RF:  bus1 = rf[rf_rd_idx];
         BUS1_MDR: bus1 = mdr;
         BUS1_SP:  bus1 = sp_bus;
         default:  bus1 = '0;
      endcase
   end

   always_comb begin
      bus2 = '0;
      case (bus2_sel_e'(bus2_sel))
         BUS2_ALU:  bus2 = alu_result;
         BUS2_BUS1: bus2 = bus1;
         BUS2_MDR:  bus2 = mdr;
         BUS2_ZERO: bus2 = '0;
         default:   bus2 = '0;
      endcase
   end

   alu_param #(.DATA_W(DATA_W)) u_alu (
      .op     (alu_op_e'(alu_sel)),
      .a      (rf[alu_a_idx]),
      .b      (bus1),
      .result (alu_result),
      .nzvc   (alu_nzvc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_state <= RD_IDLE;
      end else begin
         rd_state <= rd_next;
      end
   end

   // A request arriving while a read is outstanding is dropped, never queued
   always_comb begin
      rd_next    = rd_state;
      rd_capture = 1'b0;
      case (rd_state)
         RD_IDLE: begin
            if (mem_rd_req) begin
               rd_next = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (mem.mem_rvalid) begin
               rd_next    = RD_IDLE;
               rd_capture = 1'b1;
            end
         end
         default: rd_next = RD_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ir         <= '0;
         mar        <= '0;
         pc         <= '0;
         mdr        <= '0;
         ccr_result <= '0;
         mdr_valid  <= 1'b0;
         for (int i = 0; i < NREGS; i++) begin
            rf[i] <= '0;
         end
      end else begin
         if (ir_load) begin
            ir <= bus2;
         end
         if (mar_load) begin
            mar <= bus2[ADDR_W-1:0];
         end
         if (pc_load) begin
            pc <= bus2[ADDR_W-1:0];
         end else if (pc_inc) begin
            pc <= pc + PC_ONE;
         end
         if (rf_load) begin
            rf[rf_wr_idx] <= bus2;
         end
         if (ccr_load) begin
            ccr_result <= alu_nzvc;
         end
         if (rd_capture) begin
            mdr <= mem.mem_rdata;
         end
         mdr_valid <= rd_capture;
      end
   end

   assign mem_busy      = (rd_state == RD_WAIT);
   assign mem.mem_rd    = (rd_state == RD_WAIT);
   assign mem.address   = mar;
   assign mem.to_memory = bus1;

endmodule

// File: tb/tb_datapath_param.sv
// tb/tb_datapath_param.sv - randomized self-checking bench for datapath_param against a behavioural model
module tb_datapath_param;
   localparam int DW    = 8;
   localparam int AW    = 8;
   localparam int NR    = 4;
   localparam int DMASK = (1 << DW) - 1;
   localparam int AMASK = (1 << AW) - 1;

   logic       clk = 1'b0;
   logic       reset;
   logic       ir_load, mar_load, pc_load, pc_inc, rf_load, ccr_load;
   logic [1:0] rf_wr_idx, rf_rd_idx, alu_a_idx;
   logic [2:0] alu_sel;
   logic [1:0] bus1_sel, bus2_sel;
   logic       mem_rd_req, sp_push, sp_pop;
   logic       mem_busy, mdr_valid;
   logic [7:0] ir;
   logic [3:0] ccr_result;

   datapath_param_if #(.DATA_W(DW), .ADDR_W(AW)) mem_bus ();

   datapath_param #(.DATA_W(DW), .ADDR_W(AW), .NREGS(NR)) dut (
      .clk        (clk),
      .reset      (reset),
      .ir_load    (ir_load),
      .mar_load   (mar_load),
      .pc_load    (pc_load),
      .pc_inc     (pc_inc),
      .rf_load    (rf_load),
      .rf_wr_idx  (rf_wr_idx),
      .rf_rd_idx  (rf_rd_idx),
      .alu_a_idx  (alu_a_idx),
      .alu_sel    (alu_sel),
      .ccr_load   (ccr_load),
      .bus1_sel   (bus1_sel),
      .bus2_sel   (bus2_sel),
      .mem_rd_req (mem_rd_req),
      .sp_push    (sp_push),
      .sp_pop     (sp_pop),
      .mem_busy   (mem_busy),
      .mdr_valid  (mdr_valid),
      .ir         (ir),
      .ccr_result (ccr_result),
      .mem        (mem_bus.master)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference state: plain integers, updated once per rising edge
   int m_pc, m_mar, m_ir, m_mdr, m_ccr, m_sp;
   int m_rf [NR];
   bit m_busy, m_mv;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int to_signed(input int x);
      return (x >= (1 << (DW - 1))) ? x - (1 << DW) : x;
   endfunction

   function automatic bit out_of_range(input int s);
      return (s > (1 << (DW - 1)) - 1) || (s < -(1 << (DW - 1)));
   endfunction

   function automatic void alu_model(input int op, input int a, input int b,
                                     output int res, output int flags);
      int s;
      bit v, c;
      v = 0;
      c = 0;
      case (op)
         0: begin s = a + b; c = (s > DMASK); v = out_of_range(to_signed(a) + to_signed(b)); end
         1: begin s = a - b; c = (a < b);     v = out_of_range(to_signed(a) - to_signed(b)); end
         2: s = a & b;
         3: s = a | b;
         4: s = a ^ b;
         5: begin s = b + 1; c = (s > DMASK); v = out_of_range(to_signed(b) + 1); end
         6: begin s = b - 1; c = (b < 1);     v = out_of_range(to_signed(b) - 1); end
         default: s = b;
      endcase
      res   = s & DMASK;
      flags = ((res >= (1 << (DW - 1))) ? 8 : 0) + ((res == 0) ? 4 : 0) + (v ? 2 : 0) + (c ? 1 : 0);
   endfunction

   function automatic int m_bus1();
      case (bus1_sel)
         2'd0: return m_pc;
         2'd1: return m_rf[rf_rd_idx];
         2'd2: return m_mdr;
`ifdef DP_STACK_EN
         default: return m_sp;
`else
         default: return 0;
`endif
      endcase
   endfunction

   task automatic model_reset();
      m_pc = 0; m_mar = 0; m_ir = 0; m_mdr = 0; m_ccr = 0; m_sp = AMASK;
      m_busy = 0; m_mv = 0;
      for (int i = 0; i < NR; i++) m_rf[i] = 0;
   endtask

   task automatic compare_outputs();
      int b1, r, f;
      b1 = m_bus1();
      alu_model(alu_sel, m_rf[alu_a_idx], b1, r, f);
      check("ir", ir, m_ir);
      check("address", mem_bus.address, m_mar);
      check("to_memory", mem_bus.to_memory, b1);
      check("ccr", ccr_result, m_ccr);
      check("mem_rd", mem_bus.mem_rd, m_busy);
      check("mem_busy", mem_busy, m_busy);
      check("mdr_valid", mdr_valid, m_mv);
   endtask

   task automatic model_step();
      int b1, b2, r, f;
      b1 = m_bus1();
      alu_model(alu_sel, m_rf[alu_a_idx], b1, r, f);
      case (bus2_sel)
         2'd0: b2 = r;
         2'd1: b2 = b1;
         2'd2: b2 = m_mdr;
         default: b2 = 0;
      endcase
      if (ir_load)  m_ir = b2;
      if (mar_load) m_mar = b2 & AMASK;
      if (pc_load)  m_pc = b2 & AMASK;
      else if (pc_inc) m_pc = (m_pc + 1) & AMASK;
      if (rf_load)  m_rf[rf_wr_idx] = b2;
      if (ccr_load) m_ccr = f;
      if (m_busy) begin
         m_mv = mem_bus.mem_rvalid;
         if (mem_bus.mem_rvalid) begin
            m_mdr  = mem_bus.mem_rdata;
            m_busy = 0;
         end
      end else begin
         m_mv = 0;
         if (mem_rd_req) m_busy = 1;
      end
      if (sp_push && !sp_pop) m_sp = (m_sp - 1) & AMASK;
      else if (sp_pop && !sp_push) m_sp = (m_sp + 1) & AMASK;
   endtask

   // Entered one time unit after a rising edge; leaves one time unit after the next
   task automatic cycle();
      #2;
      compare_outputs();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic clear_inputs();
      ir_load = 0; mar_load = 0; pc_load = 0; pc_inc = 0; rf_load = 0; ccr_load = 0;
      rf_wr_idx = 0; rf_rd_idx = 0; alu_a_idx = 0; alu_sel = 0;
      bus1_sel = 0; bus2_sel = 0; mem_rd_req = 0; sp_push = 0; sp_pop = 0;
      mem_bus.mem_rvalid = 0; mem_bus.mem_rdata = 0;
   endtask

   task automatic load_rf(input logic [1:0] idx, input logic [7:0] val);
      clear_inputs();
      mem_rd_req = 1; mem_bus.mem_rdata = val;
      cycle();
      mem_rd_req = 0; mem_bus.mem_rvalid = 1;
      cycle();
      mem_bus.mem_rvalid = 0; bus2_sel = 2; rf_wr_idx = idx; rf_load = 1;
      cycle();
      rf_load = 0;
   endtask

   task automatic reset_checks();
      check("rst_ir", ir, 0);
      check("rst_address", mem_bus.address, 0);
      check("rst_ccr", ccr_result, 0);
      check("rst_mem_busy", mem_busy, 0);
      check("rst_mem_rd", mem_bus.mem_rd, 0);
      check("rst_mdr_valid", mdr_valid, 0);
   endtask

   initial begin
      int busy_cnt;
      reset = 1;
      clear_inputs();
      model_reset();
      #3;
      reset_checks();
      #10 reset = 0;
      @(posedge clk); #1;

      // PC wrap and load-over-increment priority
      clear_inputs();
      alu_sel = 6; bus1_sel = 0; bus2_sel = 0; pc_load = 1;
      cycle();
      pc_load = 0; #1;
      check("pc_loaded_ff", mem_bus.to_memory, 8'hFF);
      pc_inc = 1;
      cycle();
      pc_inc = 0; #1;
      check("pc_wrap", mem_bus.to_memory, 8'h00);
      pc_load = 1; pc_inc = 1;
      cycle();
      pc_load = 0; pc_inc = 0; #1;
      check("pc_load_wins", mem_bus.to_memory, 8'hFF);

      // Signed overflow on ADD
      load_rf(2'd1, 8'h7F);
      load_rf(2'd2, 8'h01);
      alu_a_idx = 1; bus1_sel = 1; rf_rd_idx = 2; alu_sel = 0; bus2_sel = 0;
      ccr_load = 1; ir_load = 1;
      cycle();
      ccr_load = 0; ir_load = 0; #1;
      check("add_ccr", ccr_result, 4'b1010);
      check("add_result", ir, 8'h80);

      // Same-index read and write: old value seen this cycle
      rf_rd_idx = 1; rf_wr_idx = 1; bus2_sel = 3; rf_load = 1; #1;
      check("rf_no_bypass", mem_bus.to_memory, 8'h7F);
      cycle();
      rf_load = 0; #1;
      check("rf_written", mem_bus.to_memory, 8'h00);

      // Read with three wait cycles
      clear_inputs();
      mem_rd_req = 1;
      cycle();
      mem_rd_req = 0; busy_cnt = 0;
      for (int w = 0; w < 3; w++) begin
         mem_bus.mem_rvalid = (w == 2); mem_bus.mem_rdata = 8'hA5;
         #1;
         if (mem_busy) busy_cnt++;
         cycle();
      end
      mem_bus.mem_rvalid = 0; bus1_sel = 2; #2;
      check("rd_busy_cycles", busy_cnt, 3);
      check("mdr_valid_pulse", mdr_valid, 1);
      check("mdr_a5", mem_bus.to_memory, 8'hA5);
      cycle();
      #1;
      check("mdr_valid_clear", mdr_valid, 0);

      // Reset while a read is outstanding, then a stale rvalid
      clear_inputs();
      mem_rd_req = 1;
      cycle();
      mem_rd_req = 0; bus1_sel = 2; #2;
      check("wait_busy", mem_busy, 1);
      reset = 1; model_reset(); #1;
      reset_checks();
      check("rst_mdr", mem_bus.to_memory, 0);
`ifdef DP_STACK_EN
      bus1_sel = 3; #1;
      check("rst_sp", mem_bus.to_memory, 8'hFF);
      bus1_sel = 2;
`endif
      reset = 0;
      @(posedge clk); #1;
      mem_bus.mem_rvalid = 1; mem_bus.mem_rdata = 8'h5C;
      cycle();
      mem_bus.mem_rvalid = 0; #1;
      check("late_rvalid_mdr", mem_bus.to_memory, 0);
      check("late_rvalid_valid", mdr_valid, 0);
      check("late_rvalid_idle", mem_busy, 0);

`ifdef DP_STACK_EN
      clear_inputs();
      bus1_sel = 3; sp_pop = 1;
      cycle();
      sp_pop = 0; #1;
      check("sp_pop_wrap", mem_bus.to_memory, 8'h00);
      sp_push = 1;
      cycle();
      sp_push = 0; #1;
      check("sp_push_wrap", mem_bus.to_memory, 8'hFF);
      sp_push = 1; sp_pop = 1;
      cycle();
      sp_push = 0; sp_pop = 0; #1;
      check("sp_hold", mem_bus.to_memory, 8'hFF);
`endif

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         ir_load    = ($urandom_range(3) == 0);
         mar_load   = ($urandom_range(3) == 0);
         pc_load    = ($urandom_range(5) == 0);
         pc_inc     = ($urandom_range(2) == 0);
         rf_load    = ($urandom_range(1) == 0);
         ccr_load   = ($urandom_range(1) == 0);
         rf_wr_idx  = 2'($urandom);
         rf_rd_idx  = 2'($urandom);
         alu_a_idx  = 2'($urandom);
         alu_sel    = 3'($urandom);
         bus1_sel   = 2'($urandom);
         bus2_sel   = 2'($urandom);
         mem_rd_req = ($urandom_range(2) == 0);
         sp_push    = ($urandom_range(2) == 0);
         sp_pop     = ($urandom_range(2) == 0);
         mem_bus.mem_rvalid = ($urandom_range(4) < 2);
         mem_bus.mem_rdata  = 8'($urandom);
         cycle();
      end
      clear_inputs();
      cycle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
